mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multi-cycle successor to the single-cycle decoder.
- FSM sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK across several clocks for R-type (ADD/SUB/AND/OR/SLT), ADDI, LW, SW, BEQ, BNE and J.
- Sits between the instruction register and the shared-memory multi-cycle datapath; drives all mux selects and write enables.
- Adds a variable-latency memory handshake, an illegal-instruction trap and a memory-timeout trap.

Parameters:
- OP_W, 6, opcode field width.
- FUNC_W, 6, funct field width.
- EN_BNE, 1, 1 = decode BNE (opcode 6'b000_101); 0 = BNE traps as illegal.
- MEM_TIMEOUT, 16, max wait cycles for mem_ready_in; 0 disables timeout.

Ports:
- clk_in, in, 1, clock; all state updates on rising edge.
- rst_n_in, in, 1, asynchronous active-low reset.
- op_in, in, OP_W, opcode from IR (valid from DECODE onward).
- func_in, in, FUNC_W, funct from IR.
- mem_ready_in, in, 1, memory access completes this cycle.
- pc_write_out, out, 1, unconditional PC load.
- pc_write_cond_out, out, 1, PC load qualified by ALU zero (inverted when branch_ne_out).
- branch_ne_out, out, 1, invert zero for BNE.
- pc_src_out, out, 2: 00 ALU result, 01 ALUOut, 10 jump target, 11 trap vector.
- iord_out, out, 1: 0 = PC addresses memory, 1 = ALUOut addresses memory.
- mem_read_out, out, 1, memory read strobe.
- mem_write_out, out, 1, memory write strobe.
- ir_write_out, out, 1, IR load.
- reg_dst_out, out, 1: 1 = rd, 0 = rt.
- reg_write_out, out, 1, register file write.
- mem_to_reg_out, out, 1: 1 = MDR to register file.
- alu_src_a_out, out, 1: 0 = PC, 1 = A.
- alu_src_b_out, out, 2: 00 B, 01 const 4, 10 signext imm, 11 signext imm << 2.
- alu_op_out, out, 2: 00 add, 01 sub, 10 funct-decoded.
- err_code_out, out, 2, sticky: 01 illegal, 10 mem timeout. Cleared only by reset.
- state_out, out, 4, current state encoding (debug).

Behaviour:
- Reset (rst_n_in low, asynchronous): state = FETCH, wait counter = 0, err_code_out = 00. While reset is asserted, all strobes and enables are forced 0. Selects follow FETCH values. First fetch begins on the first edge after release.
- Outputs are Moore, decoded from state. Exceptions: ir_write_out and pc_write_out in FETCH are gated by mem_ready_in.
- Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. Stay until mem_ready_in; on ready: ir_write=1, pc_write=1, go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - op 000000 with funct in {100000, 100010, 100100, 100101, 101010} -> EXEC.
  - LW/SW -> MEMADR.
  - ADDI -> ADDIEX.
  - BEQ/BNE(EN_BNE) -> BRANCH.
  - J -> JUMP.
  - Anything else, including an unknown funct -> TRAP with err_code 01.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. LW -> MEMRD; SW -> MEMWR.
- MEMRD: mem_read=1, iord=1; wait for mem_ready_in, then -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEMWR: mem_write=1, iord=1; hold until mem_ready_in, then -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
- ALUWB: reg_write=1, reg_dst=1 -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01, branch_ne=(op==BNE) -> FETCH.
- JUMP: pc_write=1, pc_src=10 -> FETCH.
- TRAP: pc_write=1, pc_src=11 for exactly one cycle -> FETCH.
- Wait counter (FETCH, MEMRD, MEMWR):
  - Increments each cycle mem_ready_in is low and clears on state exit.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT-1 with ready still low: next state = TRAP, err_code |= 10.
  - mem_ready_in arriving in the same cycle as the timeout wins; normal transition, no error.
- err_code_out bits OR-accumulate and are never cleared except by reset.
- Mid-instruction reset aborts immediately; no partial write strobe is held.
- Instruction latency with zero-wait memory: LW 5, SW 4, R-type 4, ADDI 4, BEQ/BNE 3, J 3 cycles.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the 4-bit state encodings (FETCH=0 … TRAP=12);
  - opcode/funct constants (ADD, SUB, AND, OR, SLT, ADDI, LW, SW, BEQ, BNE, J);
  - pc_src, alu_src_b and alu_op encodings.
- One sub-module, mc_wait_timer: wait counter plus timeout compare. Inputs: clear, busy, ready. Output: expire.

Test Plan:
- ADD (op 000000, funct 100000), mem_ready_in tied 1 -> state sequence 0,1,6,7,0; reg_write=1 and reg_dst=1 only in ALUWB; 4 cycles.
- LW (100011), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, mem_read=1 and iord=1 throughout; MEMWB asserts reg_write=1, mem_to_reg=1.
- BNE (000101), EN_BNE=1 -> BRANCH with pc_write_cond=1, branch_ne=1, pc_src=01. With EN_BNE=0 -> TRAP, err_code=01, pc_src=11 for one cycle.
- Illegal R-type funct 000111 -> DECODE->TRAP->FETCH; err_code_out=01 persists across later legal instructions.
- MEM_TIMEOUT=4, SW, ready never asserted -> 4 MEMWR cycles then TRAP, err_code=10. Repeat with ready in the 4th cycle -> FETCH, err_code=00.
- rst_n_in pulsed low mid-MEMWR -> mem_write_out drops asynchronously, state_out=0; first fetch after release.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM.
// Holds the 4-bit state encodings, the opcode/funct constants, the
// encodings of the pc_src / alu_src_b / alu_op selects, and a helper
// that recognises the supported R-type funct codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // pc_src encodings
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_TRAP   = 2'b11;

  // alu_src_b encodings
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // alu_op encodings
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  function automatic logic is_rtype_funct(logic [5:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Link between the control FSM and its memory wait timer.
// Handshake: busy is high while the FSM sits in a state that waits on
// memory; ready mirrors mem_ready_in; clear is pulsed on the cycle the
// FSM leaves its current state; expire is a combinational flag meaning
// "this busy cycle is the last one allowed with ready still low".
//   master (FSM)  : drives clear, busy, ready; samples expire
//   slave  (timer): samples clear, busy, ready; drives expire
interface mc_control_fsm_if;
  logic clear;
  logic busy;
  logic ready;
  logic expire;

  modport master (output clear, output busy, output ready, input expire);
  modport slave  (input clear, input busy, input ready, output expire);
endinterface

// File: rtl/mc_wait_timer.sv
// Memory wait counter with timeout compare.
// Counts cycles spent busy with ready low; clears when the FSM leaves
// the waiting state. expire flags the cycle where the count has reached
// MEM_TIMEOUT-1 and ready is still low. MEM_TIMEOUT = 0 disables expire.
// Ports: clk_in, rst_n_in (async active-low), tmr (slave side of link).
module mc_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic              clk_in,
  input logic              rst_n_in,
  mc_control_fsm_if.slave  tmr
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned LIMIT = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count <= '0;
    end else if (tmr.clear) begin
      count <= '0;
    end else if (tmr.busy && !tmr.ready) begin
      count <= count + 1'b1;
    end
  end

  // Ready arriving on the limit cycle suppresses expire, so a late
  // completion still takes the normal path.
  assign tmr.expire = (MEM_TIMEOUT != 0) && tmr.busy && !tmr.ready &&
                      (count == CNT_W'(LIMIT));

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// for R-type, ADDI, LW, SW, BEQ, BNE and J, driving every mux select and
// write enable of the shared-memory datapath.
// Inputs : clk_in, rst_n_in (async active-low), op_in/func_in from IR,
//          mem_ready_in (memory access completes this cycle).
// Outputs: PC control (pc_write, pc_write_cond, branch_ne, pc_src),
//          memory control (iord, mem_read, mem_write), ir_write,
//          register-file control (reg_dst, reg_write, mem_to_reg),
//          ALU control (alu_src_a, alu_src_b, alu_op), sticky err_code
//          (01 illegal, 10 memory timeout) and state_out for debug.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int          OP_W        = 6,
  parameter int          FUNC_W      = 6,
  parameter bit          EN_BNE      = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [OP_W-1:0]   op_in,
  input  logic [FUNC_W-1:0] func_in,
  input  logic              mem_ready_in,
  output logic              pc_write_out,
  output logic              pc_write_cond_out,
  output logic              branch_ne_out,
  output logic [1:0]        pc_src_out,
  output logic              iord_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              ir_write_out,
  output logic              reg_dst_out,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic              alu_src_a_out,
  output logic [1:0]        alu_src_b_out,
  output logic [1:0]        alu_op_out,
  output logic [1:0]        err_code_out,
  output logic [3:0]        state_out
);

  state_e     state_q, state_d;
  logic [1:0] err_q;
  logic       set_illegal, set_timeout;
  logic       pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write;
  logic [5:0] op6, fn6;

  mc_control_fsm_if tmr_if ();

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .tmr      (tmr_if)
  );

  assign op6 = 6'(op_in);
  assign fn6 = 6'(func_in);

  assign tmr_if.busy  = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                        (state_q == S_MEMWR);
  assign tmr_if.ready = mem_ready_in;
  assign tmr_if.clear = (state_d != state_q);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_q | {set_timeout, set_illegal};
    end
  end

  always_comb begin
    state_d        = state_q;
    set_illegal    = 1'b0;
    set_timeout    = 1'b0;
    pc_write       = 1'b0;
    pc_write_cond  = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    ir_write       = 1'b0;
    reg_write      = 1'b0;
    branch_ne_out  = 1'b0;
    pc_src_out     = PC_ALU;
    iord_out       = 1'b0;
    reg_dst_out    = 1'b0;
    mem_to_reg_out = 1'b0;
    alu_src_a_out  = 1'b0;
    alu_src_b_out  = SRCB_B;
    alu_op_out     = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        mem_read      = 1'b1;
        alu_src_b_out = SRCB_FOUR;
        if (mem_ready_in) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (tmr_if.expire) begin
          set_timeout = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_DECODE: begin
        // Branch target is computed here speculatively into ALUOut.
        alu_src_b_out = SRCB_IMM_SH;
        if (op6 == OP_RTYPE) begin
          if (is_rtype_funct(fn6)) begin
            state_d = S_EXEC;
          end else begin
            set_illegal = 1'b1;
            state_d     = S_TRAP;
          end
        end else if ((op6 == OP_LW) || (op6 == OP_SW)) begin
          state_d = S_MEMADR;
        end else if (op6 == OP_ADDI) begin
          state_d = S_ADDIEX;
        end else if ((op6 == OP_BEQ) || (EN_BNE && (op6 == OP_BNE))) begin
          state_d = S_BRANCH;
        end else if (op6 == OP_J) begin
          state_d = S_JUMP;
        end else begin
          set_illegal = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_MEMADR: begin
        alu_src_a_out = 1'b1;
        alu_src_b_out = SRCB_IMM;
        state_d       = (op6 == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord_out = 1'b1;
        if (mem_ready_in) begin
          state_d = S_MEMWB;
        end else if (tmr_if.expire) begin
          set_timeout = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_MEMWB: begin
        reg_write      = 1'b1;
        mem_to_reg_out = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord_out  = 1'b1;
        if (mem_ready_in) begin
          state_d = S_FETCH;
        end else if (tmr_if.expire) begin
          set_timeout = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_EXEC: begin
        alu_src_a_out = 1'b1;
        alu_src_b_out = SRCB_B;
        alu_op_out    = ALU_FUNCT;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write   = 1'b1;
        reg_dst_out = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a_out = 1'b1;
        alu_src_b_out = SRCB_IMM;
        state_d       = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_out = 1'b1;
        alu_op_out    = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src_out    = PC_ALUOUT;
        branch_ne_out = (op6 == OP_BNE);
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src_out = PC_JUMP;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        pc_write   = 1'b1;
        pc_src_out = PC_TRAP;
        state_d    = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes are masked by the raw reset so a mid-access reset drops
  // them immediately instead of waiting for the state register.
  assign pc_write_out      = pc_write      & rst_n_in;
  assign pc_write_cond_out = pc_write_cond & rst_n_in;
  assign mem_read_out      = mem_read      & rst_n_in;
  assign mem_write_out     = mem_write     & rst_n_in;
  assign ir_write_out      = ir_write      & rst_n_in;
  assign reg_write_out     = reg_write     & rst_n_in;

  assign err_code_out = err_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  localparam int W  = 23;
  localparam int T0 = 4;

  // State numbers as defined for the debug output
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4;
  localparam int P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7, P_ADDIEX = 8, P_ADDIWB = 9;
  localparam int P_BRANCH = 10, P_JUMP = 11, P_TRAP = 12;

  localparam logic [5:0] O_R = 6'b000000, O_ADDI = 6'b001000, O_LW = 6'b100011;
  localparam logic [5:0] O_SW = 6'b101011, O_BEQ = 6'b000100, O_BNE = 6'b000101;
  localparam logic [5:0] O_J = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic [5:0] op, func;
  logic       ready;

  logic       pc_write [2], pc_write_cond [2], branch_ne [2], iord [2];
  logic       mem_read [2], mem_write [2], ir_write [2], reg_dst [2];
  logic       reg_write [2], mem_to_reg [2], alu_src_a [2];
  logic [1:0] pc_src [2], alu_src_b [2], alu_op [2], err_code [2];
  logic [3:0] state [2];
  logic [W-1:0] act [2];

  for (genvar g = 0; g < 2; g++) begin : g_pack
    assign act[g] = {state[g], err_code[g], pc_write[g], pc_write_cond[g],
                     branch_ne[g], pc_src[g], iord[g], mem_read[g], mem_write[g],
                     ir_write[g], reg_dst[g], reg_write[g], mem_to_reg[g],
                     alu_src_a[g], alu_src_b[g], alu_op[g]};
  end

  mc_control_fsm #(.OP_W(6), .FUNC_W(6), .EN_BNE(1'b1), .MEM_TIMEOUT(T0)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n[0]), .op_in(op), .func_in(func),
    .mem_ready_in(ready), .pc_write_out(pc_write[0]),
    .pc_write_cond_out(pc_write_cond[0]), .branch_ne_out(branch_ne[0]),
    .pc_src_out(pc_src[0]), .iord_out(iord[0]), .mem_read_out(mem_read[0]),
    .mem_write_out(mem_write[0]), .ir_write_out(ir_write[0]),
    .reg_dst_out(reg_dst[0]), .reg_write_out(reg_write[0]),
    .mem_to_reg_out(mem_to_reg[0]), .alu_src_a_out(alu_src_a[0]),
    .alu_src_b_out(alu_src_b[0]), .alu_op_out(alu_op[0]),
    .err_code_out(err_code[0]), .state_out(state[0]));

  mc_control_fsm #(.OP_W(6), .FUNC_W(6), .EN_BNE(1'b0), .MEM_TIMEOUT(0)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n[1]), .op_in(op), .func_in(func),
    .mem_ready_in(ready), .pc_write_out(pc_write[1]),
    .pc_write_cond_out(pc_write_cond[1]), .branch_ne_out(branch_ne[1]),
    .pc_src_out(pc_src[1]), .iord_out(iord[1]), .mem_read_out(mem_read[1]),
    .mem_write_out(mem_write[1]), .ir_write_out(ir_write[1]),
    .reg_dst_out(reg_dst[1]), .reg_write_out(reg_write[1]),
    .mem_to_reg_out(mem_to_reg[1]), .alu_src_a_out(alu_src_a[1]),
    .alu_src_b_out(alu_src_b[1]), .alu_op_out(alu_op[1]),
    .err_code_out(err_code[1]), .state_out(state[1]));

  // ---------------- reference model ----------------
  int         active = 0;   // which DUT is out of reset and checked
  int         t_cur  = T0;  // its timeout setting
  bit         en_cur = 1'b1;
  logic [1:0] m_err  = 2'b00;
  logic [W-1:0] exp_q[$];
  int checks = 0, passes = 0;

  // Expected control word for one cycle spent in phase ph.
  function automatic logic [W-1:0] exp_word(int ph, logic [5:0] o, bit rdy, logic [1:0] e);
    logic pcw = 0, pwc = 0, bne = 0, io = 0, mr = 0, mw = 0, irw = 0;
    logic rd = 0, rw = 0, m2r = 0, sa = 0;
    logic [1:0] ps = 2'b00, sb = 2'b00, aop = 2'b00;
    case (ph)
      P_FETCH:  begin mr = 1; sb = 2'b01; pcw = rdy; irw = rdy; end
      P_DECODE: sb = 2'b11;
      P_MEMADR: begin sa = 1; sb = 2'b10; end
      P_MEMRD:  begin mr = 1; io = 1; end
      P_MEMWB:  begin rw = 1; m2r = 1; end
      P_MEMWR:  begin mw = 1; io = 1; end
      P_EXEC:   begin sa = 1; aop = 2'b10; end
      P_ALUWB:  begin rw = 1; rd = 1; end
      P_ADDIEX: begin sa = 1; sb = 2'b10; end
      P_ADDIWB: rw = 1;
      P_BRANCH: begin sa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; bne = (o == O_BNE); end
      P_JUMP:   begin pcw = 1; ps = 2'b10; end
      P_TRAP:   begin pcw = 1; ps = 2'b11; end
      default:  ;
    endcase
    return {4'(ph), e, pcw, pwc, bne, ps, io, mr, mw, irw, rd, rw, m2r, sa, sb, aop};
  endfunction

  // ---------------- driver ----------------
  // Called right after a rising edge: drives this cycle's inputs, queues
  // the expected outputs, then advances to just after the next edge.
  task automatic cyc(int ph, bit rdy);
    ready = rdy;
    exp_q.push_back(exp_word(ph, op, rdy, m_err));
    @(posedge clk);
    #1;
  endtask

  // A memory-waiting phase with w low-ready cycles before ready.
  task automatic mem_phase(int ph, int w, output bit to);
    int n;
    to = (t_cur != 0) && (w >= t_cur);
    n  = to ? t_cur : w;
    for (int k = 0; k < n; k++) cyc(ph, 1'b0);
    if (to) m_err = m_err | 2'b10;
    else    cyc(ph, 1'b1);
  endtask

  task automatic issue(logic [5:0] o, logic [5:0] f, int fw, int mw);
    bit to;
    op = o;
    func = f;
    mem_phase(P_FETCH, fw, to);
    if (to) begin cyc(P_TRAP, 1'($urandom_range(0, 1))); return; end
    cyc(P_DECODE, 1'($urandom_range(0, 1)));
    if (o == O_R && (f inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT})) begin
      cyc(P_EXEC, 1'($urandom_range(0, 1)));
      cyc(P_ALUWB, 1'($urandom_range(0, 1)));
    end else if (o == O_LW) begin
      cyc(P_MEMADR, 1'($urandom_range(0, 1)));
      mem_phase(P_MEMRD, mw, to);
      cyc(to ? P_TRAP : P_MEMWB, 1'($urandom_range(0, 1)));
    end else if (o == O_SW) begin
      cyc(P_MEMADR, 1'($urandom_range(0, 1)));
      mem_phase(P_MEMWR, mw, to);
      if (to) cyc(P_TRAP, 1'($urandom_range(0, 1)));
    end else if (o == O_ADDI) begin
      cyc(P_ADDIEX, 1'($urandom_range(0, 1)));
      cyc(P_ADDIWB, 1'($urandom_range(0, 1)));
    end else if (o == O_BEQ || (o == O_BNE && en_cur)) begin
      cyc(P_BRANCH, 1'($urandom_range(0, 1)));
    end else if (o == O_J) begin
      cyc(P_JUMP, 1'($urandom_range(0, 1)));
    end else begin
      m_err = m_err | 2'b01;
      cyc(P_TRAP, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic rand_issue();
    logic [5:0] o, f;
    int fw, mw;
    case ($urandom_range(0, 9))
      0, 1: o = O_R;
      2: o = O_LW;
      3: o = O_SW;
      4: o = O_ADDI;
      5: o = O_BEQ;
      6: o = O_BNE;
      7: o = O_J;
      default: o = 6'($urandom_range(0, 63));
    endcase
    case ($urandom_range(0, 5))
      0: f = F_ADD;
      1: f = F_SUB;
      2: f = F_AND;
      3: f = F_OR;
      4: f = F_SLT;
      default: f = 6'($urandom_range(0, 63));
    endcase
    fw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 1);
    mw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2);
    issue(o, f, fw, mw);
  endtask

  task automatic chk(string name, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s act=%0h exp=%0h", name, a, e);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (act[active] === e) passes++;
      else $display("FAIL ctrl dut%0d t=%0t state act=%0d exp=%0d word act=%h exp=%h",
                    active, $time, act[active][W-1 -: 4], e[W-1 -: 4], act[active], e);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    op = O_R;
    func = F_ADD;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_state", 32'(state[0]), 0);
    chk("rst_err", 32'(err_code[0]), 0);
    chk("rst_mem_read", 32'(mem_read[0]), 0);
    chk("rst_ir_write", 32'(ir_write[0]), 0);
    chk("rst_pc_write", 32'(pc_write[0]), 0);
    chk("rst_alu_src_b", 32'(alu_src_b[0]), 1);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;

    // Directed instructions on the BNE-enabled, timeout-4 instance
    issue(O_R, F_ADD, 0, 0);
    issue(O_LW, 6'd0, 0, 3);
    issue(O_SW, 6'd0, 0, 3);
    issue(O_BNE, 6'd0, 0, 0);
    issue(O_BEQ, 6'd0, 1, 0);
    issue(O_J, 6'd0, 0, 0);
    issue(O_ADDI, 6'd0, 2, 0);
    issue(O_R, F_SUB, 0, 0);
    issue(O_R, F_AND, 0, 0);
    issue(O_R, F_OR, 0, 0);
    issue(O_R, F_SLT, 0, 0);
    issue(O_R, 6'b000111, 0, 0);
    issue(O_R, F_ADD, 0, 0);
    issue(O_LW, 6'd0, 0, 0);
    repeat (150) rand_issue();

    // Reset in the middle of a store
    op = O_SW;
    func = 6'd0;
    cyc(P_FETCH, 1'b1);
    cyc(P_DECODE, 1'b0);
    cyc(P_MEMADR, 1'b0);
    cyc(P_MEMWR, 1'b0);
    cyc(P_MEMWR, 1'b0);
    chk("pre_rst_mem_write", 32'(mem_write[0]), 1);
    #2;
    rst_n[0] = 1'b0;
    m_err = 2'b00;
    #1;
    chk("mid_rst_mem_write", 32'(mem_write[0]), 0);
    chk("mid_rst_state", 32'(state[0]), 0);
    chk("mid_rst_err", 32'(err_code[0]), 0);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    issue(O_SW, 6'd0, 0, T0 + 2);
    issue(O_SW, 6'd0, 0, T0 - 1);
    issue(O_LW, 6'd0, T0, 0);
    repeat (40) rand_issue();

    // Switch to the BNE-disabled, no-timeout instance
    rst_n[0] = 1'b0;
    active = 1;
    t_cur = 0;
    en_cur = 1'b0;
    m_err = 2'b00;
    rst_n[1] = 1'b1;
    issue(O_BNE, 6'd0, 0, 0);
    issue(O_R, F_ADD, 0, 0);
    issue(O_SW, 6'd0, 20, 25);
    issue(O_LW, 6'd0, 0, 18);
    repeat (50) rand_issue();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
